// File: rtl/dout_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dout_display_pkg
// Description : Shared FSM encoding, 7-segment constants and the
//               double-dabble step helper for the dout display receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package dout_display_pkg;

    // Conversion FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Three BCD nibbles on top of an 8-bit binary field
    localparam int BCD_WIDTH   = 12;
    localparam int SHIFT_STEPS = 8;
    localparam int BIN_WIDTH   = 8;
    localparam int SREG_WIDTH  = BCD_WIDTH + BIN_WIDTH;
    localparam int CNT_WIDTH   = $clog2(SHIFT_STEPS);

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left
    function automatic logic [SREG_WIDTH-1:0] dd_step(input logic [SREG_WIDTH-1:0] s);
        logic [SREG_WIDTH-1:0] a;
        a = s;
        for (int i = 0; i < BCD_WIDTH / 4; i++) begin
            if (a[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
                a[BIN_WIDTH + 4*i +: 4] = a[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        return {a[SREG_WIDTH-2:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dout_display_rx_seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational BCD digit to active-low 7-segment pattern.
//               Blank flag or a non-decimal code turns all segments off.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import dout_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Map one BCD digit onto its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dout_display_rx.sv
`default_nettype none
// ============================================================================
// Module      : dout_display_rx
// Description : Captures new values from the SoC output bus, converts them
//               to decimal with a sequential double-dabble and drives the
//               sign/hundreds/tens/ones 7-segment displays.
// Revision    : 1.0 - initial release
// ============================================================================
module dout_display_rx
    import dout_display_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b0,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dout,
    input  logic       dval,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       busy,
    output logic       done
);

    state_t                  state;
    logic                    dval_q;
    logic [7:0]              last;
    logic [SREG_WIDTH-1:0]   sreg;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    neg;
    logic                    pend_valid;
    logic [7:0]              pend_mag;
    logic                    pend_neg;

    logic                    evt;
    logic                    in_neg;
    logic [7:0]              in_mag;
    logic [3:0]              dig_hund;
    logic [3:0]              dig_tens;
    logic [3:0]              dig_ones;
    logic                    blank_hund;
    logic                    blank_tens;
    logic [6:0]              seg_hund;
    logic [6:0]              seg_tens;
    logic [6:0]              seg_ones;

    // A new value is a dval rise, or a changed bus value while dval stays high
    assign evt = dval && (!dval_q || (dout != last));

    // Sign/magnitude split; 8'h80 negates to 8'h80 and reads as 128
    always_comb begin
        in_neg = SIGNED_MODE ? dout[7] : 1'b0;
        in_mag = in_neg ? (~dout + 8'd1) : dout;
    end

    // BCD digits and leading-zero blanking, valid when the FSM sits in UPDATE
    always_comb begin
        dig_hund   = sreg[BIN_WIDTH + 8 +: 4];
        dig_tens   = sreg[BIN_WIDTH + 4 +: 4];
        dig_ones   = sreg[BIN_WIDTH     +: 4];
        blank_hund = BLANK_LZ && (dig_hund == 4'd0);
        blank_tens = BLANK_LZ && (dig_hund == 4'd0) && (dig_tens == 4'd0);
    end

    seg7_decoder u_seg_ones (
        .bcd   (dig_ones),
        .blank (1'b0),
        .seg   (seg_ones)
    );

    seg7_decoder u_seg_tens (
        .bcd   (dig_tens),
        .blank (blank_tens),
        .seg   (seg_tens)
    );

    seg7_decoder u_seg_hund (
        .bcd   (dig_hund),
        .blank (blank_hund),
        .seg   (seg_hund)
    );

    // Event tracking, pending capture, double-dabble FSM and display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            dval_q     <= 1'b0;
            last       <= 8'h00;
            sreg       <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            pend_valid <= 1'b0;
            pend_mag   <= 8'h00;
            pend_neg   <= 1'b0;
            hex0       <= SEG_BLANK;
            hex1       <= SEG_BLANK;
            hex2       <= SEG_BLANK;
            hex3       <= SEG_BLANK;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dval_q <= dval;
            done   <= 1'b0;
            if (evt) begin
                last <= dout;
            end

            case (state)
                ST_IDLE: begin
                    if (evt) begin
                        sreg  <= {{BCD_WIDTH{1'b0}}, in_mag};
                        neg   <= in_neg;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    sreg <= dd_step(sreg);
                    if (cnt == CNT_WIDTH'(SHIFT_STEPS - 1)) begin
                        state <= ST_UPDATE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // Only the newest value arriving mid-conversion is kept
                    if (evt) begin
                        pend_valid <= 1'b1;
                        pend_mag   <= in_mag;
                        pend_neg   <= in_neg;
                    end
                end

                ST_UPDATE: begin
                    hex0 <= seg_ones;
                    hex1 <= seg_tens;
                    hex2 <= seg_hund;
                    hex3 <= neg ? SEG_MINUS : SEG_BLANK;
                    done <= 1'b1;
                    cnt  <= '0;
                    // A same-edge event is newer than anything pending, so it wins
                    if (evt) begin
                        sreg       <= {{BCD_WIDTH{1'b0}}, in_mag};
                        neg        <= in_neg;
                        pend_valid <= 1'b0;
                        state      <= ST_SHIFT;
                    end else if (pend_valid) begin
                        sreg       <= {{BCD_WIDTH{1'b0}}, pend_mag};
                        neg        <= pend_neg;
                        pend_valid <= 1'b0;
                        state      <= ST_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dout_display_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dout_display_rx
// Description : Directed self-checking bench; one unsigned and one signed
//               instance share the same bus stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dout_display_rx;

    logic       clk;
    logic       reset;
    logic [7:0] dout;
    logic       dval;

    logic [6:0] u_hex0, u_hex1, u_hex2, u_hex3;
    logic       u_busy, u_done;
    logic [6:0] s_hex0, s_hex1, s_hex2, s_hex3;
    logic       s_busy, s_done;

    int total;
    int bad;

    dout_display_rx #(.SIGNED_MODE(1'b0), .BLANK_LZ(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .dout  (dout),
        .dval  (dval),
        .hex0  (u_hex0),
        .hex1  (u_hex1),
        .hex2  (u_hex2),
        .hex3  (u_hex3),
        .busy  (u_busy),
        .done  (u_done)
    );

    dout_display_rx #(.SIGNED_MODE(1'b1), .BLANK_LZ(1'b1)) s_dut (
        .clk   (clk),
        .reset (reset),
        .dout  (dout),
        .dval  (dval),
        .hex0  (s_hex0),
        .hex1  (s_hex1),
        .hex2  (s_hex2),
        .hex3  (s_hex3),
        .busy  (s_busy),
        .done  (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive the bus between edges; the following posedge is sampling edge k
    task automatic apply(input logic [7:0] d, input logic v);
        @(negedge clk);
        dout = d;
        dval = v;
    endtask

    // Count edges after k until done is seen (bounded); returns 9 for nominal latency
    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 30) begin
            @(posedge clk);
            #1;
            if (u_done) seen = 1'b1;
            else        n++;
        end
        if (!seen) n = 99;
    endtask

    int n;
    int dcount;
    int first_done;
    int second_done;
    int busy_drop;
    logic [27:0] snap1;
    logic [27:0] snap2;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        dout  = 8'h00;
        dval  = 1'b0;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_u_hex", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("rst_s_hex", {s_hex3, s_hex2, s_hex1, s_hex0}, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("rst_busy_done", {u_busy, u_done, s_busy, s_done}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 2: 255 -> unsigned "255", signed "-1"
        apply(8'd255, 1'b1);
        wait_done(n);
        chk("lat_255", n, 9);
        chk("u_255", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h24, 7'h12, 7'h12});
        chk("s_255", {s_hex3, s_hex2, s_hex1, s_hex0}, {7'h3F, 7'h7F, 7'h7F, 7'h79});
        chk("s_done_255", s_done, 1'b1);
        chk("busy_after_255", u_busy, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", u_done, 1'b0);

        // 3: leading-zero blanking
        apply(8'd7, 1'b1);
        wait_done(n);
        chk("lat_7", n, 9);
        chk("u_7", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h7F, 7'h7F, 7'h78});
        chk("s_7", {s_hex3, s_hex2, s_hex1, s_hex0}, {7'h7F, 7'h7F, 7'h7F, 7'h78});
        apply(8'd100, 1'b1);
        wait_done(n);
        chk("u_100", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h79, 7'h40, 7'h40});

        // Holding dval with an unchanged value must not retrigger
        dcount = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (u_done) dcount++;
        end
        chk("hold_no_event", dcount, 0);

        // 4: signed extremes
        apply(8'h80, 1'b1);
        wait_done(n);
        chk("s_m128", {s_hex3, s_hex2, s_hex1, s_hex0}, {7'h3F, 7'h79, 7'h24, 7'h00});
        chk("u_128", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h79, 7'h24, 7'h00});
        apply(8'hFF, 1'b1);
        wait_done(n);
        chk("s_m1", {s_hex3, s_hex2, s_hex1, s_hex0}, {7'h3F, 7'h7F, 7'h7F, 7'h79});

        // 5: overrun 11, 22, 33 on consecutive edges
        apply(8'd11, 1'b1);
        dcount      = 0;
        first_done  = -1;
        second_done = -1;
        busy_drop   = -1;
        snap1       = '0;
        snap2       = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (u_done) begin
                dcount++;
                if (first_done < 0) begin
                    first_done = i;
                    snap1 = {u_hex3, u_hex2, u_hex1, u_hex0};
                end else if (second_done < 0) begin
                    second_done = i;
                    snap2 = {u_hex3, u_hex2, u_hex1, u_hex0};
                end
            end
            if (!u_busy && busy_drop < 0) busy_drop = i;
            if (i == 0) dout = 8'd22;
            if (i == 1) dout = 8'd33;
        end
        chk("ovr_first_at", first_done, 9);
        chk("ovr_first_val", snap1, {7'h7F, 7'h7F, 7'h79, 7'h79});
        chk("ovr_second_at", second_done, 18);
        chk("ovr_second_val", snap2, {7'h7F, 7'h7F, 7'h30, 7'h30});
        chk("ovr_done_count", dcount, 2);
        chk("ovr_busy_drop", busy_drop, 18);

        // 6: reset during the fourth shift cycle
        apply(8'd0, 1'b0);
        repeat (2) @(posedge clk);
        apply(8'd44, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        dval  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_hex", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("mid_rst_busy_done", {u_busy, u_done, s_busy, s_done}, 4'b0000);
        reset  = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (u_done || s_done) dcount++;
        end
        chk("mid_rst_no_done", dcount, 0);
        apply(8'd44, 1'b1);
        wait_done(n);
        chk("lat_44", n, 9);
        chk("u_44", {u_hex3, u_hex2, u_hex1, u_hex0}, {7'h7F, 7'h7F, 7'h19, 7'h19});

        // dval 1->0->1 with the same value re-converts
        apply(8'd44, 1'b0);
        repeat (2) @(posedge clk);
        apply(8'd44, 1'b1);
        wait_done(n);
        chk("reconvert_lat", n, 9);
        chk("s_44", {s_hex3, s_hex2, s_hex1, s_hex0}, {7'h7F, 7'h7F, 7'h19, 7'h19});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
